// File: rtl/dps_decoder_16_pkg.sv
// Shared widths and weight table for the 16-wire DPS encoder/decoder pair.
// The Fibonacci numeral system (FNS) weights are computed here so both ends use one table.
package dps_decoder_16_pkg;

    localparam int DBLEN16  = 12;
    localparam int CODE_W   = 16;
    localparam int N_GROUPS = 4;

    typedef logic [DBLEN16-1:0] data_t;
    typedef logic [CODE_W-1:0]  code_t;

    // FNS(n): 1, 1, 2, 3, 5, ... for n = 1, 2, 3, ...
    function automatic data_t fns(input int n);
        data_t a = data_t'(1);
        data_t b = data_t'(1);
        data_t t;
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Weight of codeword wire k.
    function automatic data_t dps16_w(input int k);
        if (k == 0)
            return data_t'(1);
        else if (k <= 13)
            return fns(k + 1);
        else if (k == 14)
            return data_t'(2) * fns(15);
        else
            return fns(16);
    endfunction

endpackage

// File: rtl/dps_xt_checker_16.sv
// Flags adjacent wires toggling in opposite directions between consecutive accepted codewords.
// Instantiated by dps_decoder_16 only when XT_CHECK_EN is defined.
module dps_xt_checker_16
    import dps_decoder_16_pkg::*;
(
    input  logic  clock,
    input  logic  rst_n,
    input  logic  i_accept,
    input  code_t i_code,
    input  logic  i_clr,
    output logic  o_err
);

    code_t r_prev;
    logic  r_err;
    code_t w_rise;
    code_t w_fall;
    logic  w_hit;

    assign w_rise = ~r_prev & i_code;
    assign w_fall = r_prev & ~i_code;
    assign w_hit  = i_accept &
                    (|((w_rise[CODE_W-2:0] & w_fall[CODE_W-1:1]) |
                       (w_fall[CODE_W-2:0] & w_rise[CODE_W-1:1])));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_err  <= 1'b0;
        end else begin
            if (i_accept)
                r_prev <= i_code;
            // Clear has priority over a set in the same cycle.
            if (i_clr)
                r_err <= 1'b0;
            else if (w_hit)
                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/dps_decoder_16.sv
// DPS 16-wire codeword -> DBLEN16-bit data decoder, 3-stage valid/ready pipeline.
// Define XT_CHECK_EN to add the xt_err/xt_clr crosstalk-transition checker.
module dps_decoder_16
    import dps_decoder_16_pkg::*;
(
    input  logic               clock,
    input  logic               rst_n,
    input  logic [CODE_W-1:0]  code_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DBLEN16-1:0] data_out,
    output logic               out_valid,
    input  logic               out_ready
`ifdef XT_CHECK_EN
    ,
    output logic               xt_err,
    input  logic               xt_clr
`endif
);

    logic  r_s1_v;
    logic  r_s2_v;
    logic  r_s3_v;
    code_t r_s1_code;
    data_t r_part [N_GROUPS];
    data_t r_data_out;

    logic  w_s3_load;
    logic  w_s2_adv;
    logic  w_s2_load;
    logic  w_s1_adv;
    logic  w_s1_load;
    logic  w_accept;
    data_t w_term [CODE_W];
    data_t w_part [N_GROUPS];
    data_t w_sum;

    // Backward ready chain: a stage may load when empty or when it empties this cycle.
    assign w_s3_load = ~r_s3_v | out_ready;
    assign w_s2_adv  = r_s2_v & w_s3_load;
    assign w_s2_load = ~r_s2_v | w_s2_adv;
    assign w_s1_adv  = r_s1_v & w_s2_load;
    assign w_s1_load = ~r_s1_v | w_s1_adv;
    assign w_accept  = in_valid & w_s1_load;
    assign in_ready  = w_s1_load;

    for (genvar k = 0; k < CODE_W; k++) begin : g_term
        assign w_term[k] = r_s1_code[k] ? dps16_w(k) : '0;
    end

    for (genvar g = 0; g < N_GROUPS; g++) begin : g_part
        assign w_part[g] = w_term[4*g] + w_term[4*g+1] + w_term[4*g+2] + w_term[4*g+3];
    end

    assign w_sum = r_part[0] + r_part[1] + r_part[2] + r_part[3];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s3_v     <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_s1_load)
                r_s1_v <= in_valid;
            if (w_s2_load)
                r_s2_v <= r_s1_v;
            if (w_s3_load)
                r_s3_v <= r_s2_v;
            if (w_s2_adv)
                r_data_out <= w_sum;
        end
    end

    // NOTE: internal data registers are qualified by their stage valid, so they carry no reset.
    always_ff @(posedge clock) begin
        if (w_accept)
            r_s1_code <= code_in;
        if (w_s1_adv)
            r_part <= w_part;
    end

    assign data_out  = r_data_out;
    assign out_valid = r_s3_v;

`ifdef XT_CHECK_EN
    dps_xt_checker_16 u_xt_checker (
        .clock    (clock),
        .rst_n    (rst_n),
        .i_accept (w_accept),
        .i_code   (code_in),
        .i_clr    (xt_clr),
        .o_err    (xt_err)
    );
`endif

endmodule

// File: tb/tb_dps_decoder_16.sv
// Directed self-checking bench for dps_decoder_16 (XT_CHECK_EN sections compile only when defined).
module tb_dps_decoder_16;
    import dps_decoder_16_pkg::*;

    typedef struct {
        logic [15:0] code;
        logic [11:0] exp;
    } vec_t;

    // Weights: 1,1,2,3,5,8,13,21,34,55,89,144,233,377,1220,987
    vec_t vecs [12] = '{
        '{16'h0000, 12'd0},    '{16'h0001, 12'd1},    '{16'h0002, 12'd1},
        '{16'h0004, 12'd2},    '{16'h00F0, 12'd47},   '{16'h0F00, 12'd322},
        '{16'h2000, 12'd377},  '{16'h5555, 12'd1597}, '{16'hAAAA, 12'd1596},
        '{16'hFFFF, 12'd3193}, '{16'h4000, 12'd1220}, '{16'h8000, 12'd987}
    };

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] code_in;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] data_out;
    logic        out_valid;
    logic        out_ready;
`ifdef XT_CHECK_EN
    logic        xt_err;
    logic        xt_clr;
`endif

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          n_acc = 0;
    int          cyc   = 0;
    logic [11:0] cur_exp;
    logic [11:0] exp_q [$];

    dps_decoder_16 dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef XT_CHECK_EN
        ,
        .xt_err    (xt_err),
        .xt_clr    (xt_clr)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: queue expected value on accept, compare on output handshake.
    always @(negedge clock) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            n_acc++;
        end
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            check("out_has_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
                check("data", data_out, exp_q.pop_front());
        end
    end

    task automatic send(input vec_t v);
        int b = 0;
        code_in  = v.code;
        cur_exp  = v.exp;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && b < 50) begin
            @(negedge clock);
            b++;
        end
        if (b >= 50)
            check("accept_timeout", b, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 50) begin
            @(posedge clock);
            #1;
            b++;
        end
        check("drain_empty", exp_q.size(), 0);
        check("no_loss_dup", n_out, n_acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t0;
        int k;
        int base;
        logic acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        code_in   = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
`ifdef XT_CHECK_EN
        xt_clr    = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef XT_CHECK_EN
        check("rst_xt_err", xt_err, 0);
`endif
        @(negedge clock);
        rst_n = 1'b1;

        // Latency: word presented before edge 1 is visible after edge 3.
        @(posedge clock);
        #1;
        code_in  = 16'h0000;
        cur_exp  = 12'd0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        drain();

`ifdef XT_CHECK_EN
        // 0001 -> 0002: bit0 falls while bit1 rises.
        send(vecs[1]);
        check("xt_after_0001", xt_err, 0);
        send(vecs[2]);
        check("xt_after_0002", xt_err, 1);
        xt_clr = 1'b1;
        @(posedge clock);
        #1;
        xt_clr = 1'b0;
        check("xt_cleared", xt_err, 0);
        // 0002 -> 0003 -> 000F: rises only.
        send('{16'h0003, 12'd2});
        send('{16'h000F, 12'd7});
        check("xt_quiet", xt_err, 0);
        // 000F -> 0010 is forbidden, but a same-cycle clear wins.
        xt_clr = 1'b1;
        send('{16'h0010, 12'd5});
        xt_clr = 1'b0;
        check("xt_clear_wins", xt_err, 0);
        drain();
`endif

        // Throughput: 12 words back to back in 12 cycles.
        t0 = cyc;
        for (int i = 0; i < 12; i++)
            send(vecs[i]);
        check("throughput_cycles", cyc - t0, 12);
        drain();

        // Backpressure: pipeline fills with 3 words, output held.
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            code_in  = vecs[7 + k].code;
            cur_exp  = vecs[7 + k].exp;
            in_valid = 1'b1;
            @(negedge clock);
            acc = in_ready;
            if (c == 4)
                check("bp_hold_mid", data_out, 1597);
            @(posedge clock);
            #1;
            if (acc)
                k++;
        end
        in_valid = 1'b0;
        check("bp_accepted", k, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_end", data_out, 1597);
        check("bp_no_emit", n_out, n_acc - 3);

        // Release with a new word offered: full pipe must take it in the same cycle.
        out_ready = 1'b1;
        code_in   = vecs[10].code;
        cur_exp   = vecs[10].exp;
        in_valid  = 1'b1;
        @(negedge clock);
        check("full_pass_through", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with two words in flight.
        send(vecs[4]);
        send(vecs[5]);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data_out", data_out, 0);
        exp_q.delete();
        n_acc = n_out;
        base  = n_out;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("midrst_no_emit", n_out, base);
        check("midrst_out_idle", out_valid, 0);

        // Pipeline still works after the reset.
        send(vecs[9]);
        send(vecs[11]);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
